siganfu_fire_arbiter: RTL and testbench

Round-robin fire-control arbiter that shares a single SIGANFU machine gun between up to NREQ targeting stations. It grants the gun to one station at a time and drives the gun's target_locked / is_enemy / fire_command / firing_mode inputs from the granted station. Each tenure is bounded by a shot budget and a cycle timeout, and the gun's reported current_state is monitored so that a downfall condition halts all firing. It sits between the station request logic and the machine-gun core, fully synchronous, with no internal delays.

---
 rtl/siganfu_fire_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 tb/tb_siganfu_fire_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siganfu_fire_arbiter.sv
// siganfu_fire_arbiter
//
// Round-robin fire-control arbiter that shares one SIGANFU machine gun between
// NREQ targeting stations. One station at a time holds the gun (a "tenure").
// While it does, its lock/enemy/request flags are mirrored onto the gun inputs.
// A tenure ends in one of four ways:
//   - the station drops its request
//   - the shot budget is reached
//   - the tenure times out
//   - the gun reports downfall, which stops all firing until reboot_n
//
// Ports
//   sysclk            rising-edge system clock
//   reboot_n          asynchronous active-low reset
//   req               per-station fire request (level)
//   req_locked        per-station target-locked flag
//   req_enemy         per-station IFF-enemy flag
//   req_auto          per-station mode request (1 auto, 0 single)
//   gun_state         gun current_state (000 idle ... 101 downfall)
//   gun_fire_trigger  gun fire_trigger, one shot per rising edge
//   gnt               one-hot grant (registered)
//   gun_target_locked gun target_locked, mirrored from the granted station
//   gun_is_enemy      gun is_enemy, mirrored from the granted station
//   gun_fire_command  gun fire_command = req & locked & enemy of the grantee
//   gun_firing_mode   gun firing_mode, latched when the grant is issued
//   shot_count        shots in the current or most recent tenure
//   release_pulse     one-cycle pulse when a tenure ends
//   release_cause     00 drop, 01 burst, 10 timeout, 11 downfall
//   halted            sticky downfall indication
module siganfu_fire_arbiter #(
  parameter int NREQ      = 4,
  parameter int BURST_MAX = 8,
  parameter int HOLD_MAX  = 64,
  parameter int GUARD     = 2
) (
  input  logic            sysclk,
  input  logic            reboot_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] req_locked,
  input  logic [NREQ-1:0] req_enemy,
  input  logic [NREQ-1:0] req_auto,
  input  logic [2:0]      gun_state,
  input  logic            gun_fire_trigger,
  output logic [NREQ-1:0] gnt,
  output logic            gun_target_locked,
  output logic            gun_is_enemy,
  output logic            gun_fire_command,
  output logic            gun_firing_mode,
  output logic [7:0]      shot_count,
  output logic            release_pulse,
  output logic [1:0]      release_cause,
  output logic            halted
);

  localparam int IW = $clog2(NREQ);

  localparam logic [2:0] GS_RELOAD   = 3'b011;
  localparam logic [2:0] GS_OVERHEAT = 3'b100;
  localparam logic [2:0] GS_DOWNFALL = 3'b101;

  localparam logic [1:0] CAUSE_DROP    = 2'b00;
  localparam logic [1:0] CAUSE_BURST   = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] CAUSE_DOWN    = 2'b11;

  localparam logic [7:0] BURST_LIM  = 8'(BURST_MAX);
  localparam logic [9:0] HOLD_LIM   = 10'(HOLD_MAX);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FIRE  = 2'b01,
    ST_GUARD = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  // First set request bit at or after ptr, wrapping modulo NREQ.
  function automatic logic [IW-1:0] pick_winner(input logic [NREQ-1:0] r,
                                                input logic [IW-1:0]   ptr);
    logic [IW-1:0] w;
    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    w     = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum   = {1'b0, ptr} + (IW+1)'(k);
      idx   = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : IW'(sum);
      w     = (!found && r[idx]) ? idx : w;
      found = found | r[idx];
    end
    return w;
  endfunction

  // Pointer successor; NREQ need not be a power of two, so wrap explicitly.
  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] w);
    return (w == IW'(NREQ - 1)) ? {IW{1'b0}} : w + IW'(1);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] w);
    logic [NREQ-1:0] v;
    v    = {NREQ{1'b0}};
    v[w] = 1'b1;
    return v;
  endfunction

  // Registered state
  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   win_r;
  logic [9:0]      tenure_r;
  logic [3:0]      guard_cnt_r;
  logic            trig_r;
  logic            trig_d_r;
  logic [NREQ-1:0] gnt_r;
  logic            locked_r;
  logic            enemy_r;
  logic            fire_r;
  logic            mode_r;
  logic [7:0]      shot_count_r;
  logic            rel_pulse_r;
  logic [1:0]      rel_cause_r;
  logic            halted_r;

  // Next-state values
  state_t          state_nxt;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   win_nxt;
  logic [9:0]      tenure_nxt;
  logic [3:0]      guard_cnt_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic            locked_nxt;
  logic            enemy_nxt;
  logic            fire_nxt;
  logic            mode_nxt;
  logic [7:0]      shot_count_nxt;
  logic            rel_pulse_nxt;
  logic [1:0]      rel_cause_nxt;
  logic            halted_nxt;

  // Combinational helpers
  logic [IW-1:0]   win_s;
  logic            tenure_inc_s;
  logic [9:0]      tenure_s;
  logic            shot_rise_s;
  logic            exit_s;
  logic            to_halt_s;
  logic [1:0]      cause_s;

  // Outputs come straight from flops.
  assign gnt               = gnt_r;
  assign gun_target_locked = locked_r;
  assign gun_is_enemy      = enemy_r;
  assign gun_fire_command  = fire_r;
  assign gun_firing_mode   = mode_r;
  assign shot_count        = shot_count_r;
  assign release_pulse     = rel_pulse_r;
  assign release_cause     = rel_cause_r;
  assign halted            = halted_r;

  // FSM state register
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Trigger input register plus one delayed copy for rising-edge detection
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      trig_r   <= 1'b0;
      trig_d_r <= 1'b0;
    end else begin
      trig_r   <= gun_fire_trigger;
      trig_d_r <= trig_r;
    end
  end

  // Datapath and output registers
  always_ff @(posedge sysclk or negedge reboot_n) begin
    if (!reboot_n) begin
      ptr_r        <= {IW{1'b0}};
      win_r        <= {IW{1'b0}};
      tenure_r     <= 10'd0;
      guard_cnt_r  <= 4'd0;
      gnt_r        <= {NREQ{1'b0}};
      locked_r     <= 1'b0;
      enemy_r      <= 1'b0;
      fire_r       <= 1'b0;
      mode_r       <= 1'b0;
      shot_count_r <= 8'd0;
      rel_pulse_r  <= 1'b0;
      rel_cause_r  <= 2'b00;
      halted_r     <= 1'b0;
    end else begin
      ptr_r        <= ptr_nxt;
      win_r        <= win_nxt;
      tenure_r     <= tenure_nxt;
      guard_cnt_r  <= guard_cnt_nxt;
      gnt_r        <= gnt_nxt;
      locked_r     <= locked_nxt;
      enemy_r      <= enemy_nxt;
      fire_r       <= fire_nxt;
      mode_r       <= mode_nxt;
      shot_count_r <= shot_count_nxt;
      rel_pulse_r  <= rel_pulse_nxt;
      rel_cause_r  <= rel_cause_nxt;
      halted_r     <= halted_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state_r;
    ptr_nxt        = ptr_r;
    win_nxt        = win_r;
    tenure_nxt     = tenure_r;
    guard_cnt_nxt  = guard_cnt_r;
    gnt_nxt        = gnt_r;
    locked_nxt     = locked_r;
    enemy_nxt      = enemy_r;
    fire_nxt       = fire_r;
    mode_nxt       = mode_r;
    shot_count_nxt = shot_count_r;
    rel_pulse_nxt  = 1'b0;
    rel_cause_nxt  = rel_cause_r;
    halted_nxt     = halted_r;

    win_s        = pick_winner(req, ptr_r);
    // Reload and overheat do not use up the station's time slot.
    tenure_inc_s = (gun_state != GS_RELOAD) && (gun_state != GS_OVERHEAT);
    // Count including the current cycle, so a tenure lasts exactly
    // HOLD_MAX counted FIRE cycles.
    tenure_s     = tenure_inc_s ? tenure_r + 10'd1 : tenure_r;
    shot_rise_s  = trig_r & ~trig_d_r;
    exit_s       = 1'b0;
    to_halt_s    = 1'b0;
    cause_s      = CAUSE_DROP;

    case (state_r)
      ST_IDLE: begin
        if (gun_state == GS_DOWNFALL) begin
          state_nxt  = ST_HALT;
          halted_nxt = 1'b1;
        end else if (|req) begin
          state_nxt      = ST_FIRE;
          win_nxt        = win_s;
          gnt_nxt        = onehot(win_s);
          mode_nxt       = req_auto[win_s];
          shot_count_nxt = 8'd0;
          tenure_nxt     = 10'd0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      ST_FIRE: begin
        // Exit checks in priority order; only the first match is reported.
        exit_s = 1'b1;
        if (gun_state == GS_DOWNFALL) begin
          cause_s   = CAUSE_DOWN;
          to_halt_s = 1'b1;
        end else if (!req[win_r]) begin
          cause_s = CAUSE_DROP;
        end else if (shot_count_r == BURST_LIM) begin
          cause_s = CAUSE_BURST;
        end else if (tenure_s == HOLD_LIM) begin
          cause_s = CAUSE_TIMEOUT;
        end else begin
          exit_s = 1'b0;
        end

        if (exit_s) begin
          gnt_nxt       = {NREQ{1'b0}};
          locked_nxt    = 1'b0;
          enemy_nxt     = 1'b0;
          fire_nxt      = 1'b0;
          mode_nxt      = 1'b0;
          rel_pulse_nxt = 1'b1;
          rel_cause_nxt = cause_s;
          if (to_halt_s) begin
            state_nxt  = ST_HALT;
            halted_nxt = 1'b1;
          end else begin
            state_nxt     = ST_GUARD;
            ptr_nxt       = next_ptr(win_r);
            guard_cnt_nxt = 4'd0;
          end
        end else begin
          state_nxt  = ST_FIRE;
          locked_nxt = req_locked[win_r];
          enemy_nxt  = req_enemy[win_r];
          fire_nxt   = req[win_r] & req_locked[win_r] & req_enemy[win_r];
          tenure_nxt = tenure_s;
          if (shot_rise_s && (shot_count_r != 8'hFF)) begin
            shot_count_nxt = shot_count_r + 8'd1;
          end else begin
            shot_count_nxt = shot_count_r;
          end
        end
      end

      ST_GUARD: begin
        if (gun_state == GS_DOWNFALL) begin
          state_nxt  = ST_HALT;
          halted_nxt = 1'b1;
        end else if (guard_cnt_r == GUARD_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          guard_cnt_nxt = guard_cnt_r + 4'd1;
        end
      end

      ST_HALT: begin
        // Only reboot_n leaves this state.
        state_nxt  = ST_HALT;
        gnt_nxt    = {NREQ{1'b0}};
        locked_nxt = 1'b0;
        enemy_nxt  = 1'b0;
        fire_nxt   = 1'b0;
        mode_nxt   = 1'b0;
        halted_nxt = 1'b1;
      end

      default: begin
        state_nxt  = ST_IDLE;
        gnt_nxt    = {NREQ{1'b0}};
        locked_nxt = 1'b0;
        enemy_nxt  = 1'b0;
        fire_nxt   = 1'b0;
        mode_nxt   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_siganfu_fire_arbiter.sv
// Self-checking bench for siganfu_fire_arbiter (default parameters).
// The table drives back-to-back single-cycle-style tenures to exercise the
// round-robin pointer. Hand-written sequences then cover:
//   - burst budget
//   - round-robin timeouts
//   - timeout with freeze
//   - mode latch
//   - downfall
//   - asynchronous reset
// A negedge scoreboard pops the expected grant / release records queued by
// the stimulus.
module tb_siganfu_fire_arbiter;

  localparam int NREQ  = 4;
  localparam int GUARD = 2;
  localparam int HOLD  = 64;

  logic            clk;
  logic            reboot_n;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_locked;
  logic [NREQ-1:0] req_enemy;
  logic [NREQ-1:0] req_auto;
  logic [2:0]      gun_state;
  logic            gun_fire_trigger;
  logic [NREQ-1:0] gnt;
  logic            gun_target_locked;
  logic            gun_is_enemy;
  logic            gun_fire_command;
  logic            gun_firing_mode;
  logic [7:0]      shot_count;
  logic            release_pulse;
  logic [1:0]      release_cause;
  logic            halted;

  siganfu_fire_arbiter #(
    .NREQ(NREQ), .BURST_MAX(8), .HOLD_MAX(HOLD), .GUARD(GUARD)
  ) dut (
    .sysclk(clk), .reboot_n(reboot_n),
    .req(req), .req_locked(req_locked), .req_enemy(req_enemy), .req_auto(req_auto),
    .gun_state(gun_state), .gun_fire_trigger(gun_fire_trigger),
    .gnt(gnt), .gun_target_locked(gun_target_locked), .gun_is_enemy(gun_is_enemy),
    .gun_fire_command(gun_fire_command), .gun_firing_mode(gun_firing_mode),
    .shot_count(shot_count), .release_pulse(release_pulse),
    .release_cause(release_cause), .halted(halted)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] lk;
    logic [3:0] en;
    logic [3:0] au;
    logic [3:0] gnt;
    logic       fire;
    logic       mode;
    logic       tl;
    logic       ie;
  } vec_t;

  vec_t        tbl [8];
  logic [3:0]  rr_exp [5];
  logic [3:0]  gnt_q [$];
  logic [9:0]  rel_q [$];   // {cause[1:0], shots[7:0]}
  logic [3:0]  prev_gnt;
  int          total;
  int          bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every new grant and every release pulse is matched against the queue
  always @(negedge clk) begin
    if (reboot_n) begin
      if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
        if (gnt_q.size() == 0) begin
          check("sb_gnt_unexpected", 32'(gnt), 32'd0);
        end else begin
          check("sb_gnt", 32'(gnt), 32'(gnt_q[0]));
          check("sb_gnt_shots", 32'(shot_count), 32'd0);
          void'(gnt_q.pop_front());
        end
      end
      if (release_pulse) begin
        if (rel_q.size() == 0) begin
          check("sb_rel_unexpected", 32'(release_pulse), 32'd0);
        end else begin
          check("sb_rel_cause", 32'(release_cause), 32'(rel_q[0][9:8]));
          check("sb_rel_shots", 32'(shot_count), 32'(rel_q[0][7:0]));
          void'(rel_q.pop_front());
        end
      end
    end
    prev_gnt <= gnt;
  end

  initial begin
    int n;
    total = 0;
    bad   = 0;
    prev_gnt = 4'b0000;

    // {req, locked, enemy, auto, exp gnt, exp fire, exp mode, exp locked, exp enemy}
    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[1] = '{4'b0101, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{4'b1010, 4'b1010, 4'b0010, 4'b1000, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{4'b1011, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{4'b0110, 4'b0100, 4'b0110, 4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b1, 1'b1};
    rr_exp[0] = 4'b0010;
    rr_exp[1] = 4'b0100;
    rr_exp[2] = 4'b1000;
    rr_exp[3] = 4'b0001;
    rr_exp[4] = 4'b0010;

    // Reset state
    reboot_n = 1'b0;
    req = 4'b0000; req_locked = 4'b0000; req_enemy = 4'b0000; req_auto = 4'b0000;
    gun_state = 3'b000; gun_fire_trigger = 1'b0;
    step(); step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_fire", 32'(gun_fire_command), 32'd0);
    check("rst_mode", 32'(gun_firing_mode), 32'd0);
    check("rst_shots", 32'(shot_count), 32'd0);
    check("rst_rel", 32'({release_pulse, release_cause}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    reboot_n = 1'b1;
    step();

    // Table: grant, mirror outputs, drop, guard
    for (int i = 0; i < 8; i++) begin
      req = tbl[i].req; req_locked = tbl[i].lk; req_enemy = tbl[i].en; req_auto = tbl[i].au;
      gnt_q.push_back(tbl[i].gnt);
      step();
      check("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      check("tbl_mode", 32'(gun_firing_mode), 32'(tbl[i].mode));
      check("tbl_fire_early", 32'(gun_fire_command), 32'd0);
      step();
      check("tbl_fire", 32'(gun_fire_command), 32'(tbl[i].fire));
      check("tbl_locked", 32'(gun_target_locked), 32'(tbl[i].tl));
      check("tbl_enemy", 32'(gun_is_enemy), 32'(tbl[i].ie));
      req = 4'b0000;
      rel_q.push_back({2'b00, 8'd0});
      step();
      check("tbl_drop_gnt", 32'(gnt), 32'd0);
      check("tbl_drop_pulse", 32'(release_pulse), 32'd1);
      repeat (GUARD) step();
    end

    // Single requester, burst budget of 8 shots, trigger every 4 cycles
    req = 4'b0001; req_locked = 4'b1111; req_enemy = 4'b1111; req_auto = 4'b1111;
    gnt_q.push_back(4'b0001);
    rel_q.push_back({2'b01, 8'd8});
    step();
    check("burst_gnt", 32'(gnt), 32'b0001);
    n = 0;
    while (!release_pulse && n < 200) begin
      gun_fire_trigger = (n % 4 == 0);
      step();
      n++;
    end
    gun_fire_trigger = 1'b0;
    check("burst_release", 32'(release_pulse), 32'd1);
    check("burst_cause", 32'(release_cause), 32'b01);
    check("burst_len", 32'(n), 32'd31);
    check("burst_gap0", 32'(gnt), 32'd0);
    gnt_q.push_back(4'b0001);
    step();
    check("burst_gap1", 32'(gnt), 32'd0);
    check("burst_shots_hold", 32'(shot_count), 32'd8);
    check("burst_pulse_once", 32'(release_pulse), 32'd0);
    step();
    check("burst_gap2", 32'(gnt), 32'd0);
    step();
    check("burst_regrant", 32'(gnt), 32'b0001);
    check("burst_regrant_shots", 32'(shot_count), 32'd0);
    req = 4'b0000;
    rel_q.push_back({2'b00, 8'd0});
    step();
    repeat (GUARD) step();

    // Round-robin with all four requesting, tenures end by timeout
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back(rr_exp[i]);
      rel_q.push_back({(i == 4) ? 2'b00 : 2'b10, 8'd0});
    end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (gnt == 4'b0000 && n < 20) begin
        step();
        n++;
      end
      check("rr_gnt", 32'(gnt), 32'(rr_exp[i]));
      if (i > 0) check("rr_gap", 32'(n), 32'(GUARD + 1));
      if (i == 4) req = 4'b0000;
      n = 0;
      while (!release_pulse && n < 200) begin
        step();
        n++;
      end
      check("rr_release", 32'(release_pulse), 32'd1);
      if (i < 4) check("rr_hold_len", 32'(n), 32'(HOLD));
    end
    repeat (GUARD) step();

    // Timeout with 20 frozen (overheat) cycles: 64 counted, 84 FIRE cycles
    req = 4'b0100;
    gnt_q.push_back(4'b0100);
    rel_q.push_back({2'b10, 8'd0});
    step();
    check("frz_gnt", 32'(gnt), 32'b0100);
    n = 0;
    while (!release_pulse && n < 200) begin
      gun_state = (n >= 10 && n < 30) ? 3'b100 : 3'b000;
      step();
      n++;
    end
    gun_state = 3'b000;
    check("frz_cause", 32'(release_cause), 32'b10);
    check("frz_len", 32'(n), 32'd84);
    req = 4'b0000;
    repeat (GUARD) step();

    // Mode latched at grant, then request drop
    req = 4'b1000; req_auto = 4'b0000;
    gnt_q.push_back(4'b1000);
    rel_q.push_back({2'b00, 8'd0});
    step();
    check("mode_gnt", 32'(gnt), 32'b1000);
    check("mode_init", 32'(gun_firing_mode), 32'd0);
    req_auto = 4'b1111;
    step(); step();
    check("mode_latched", 32'(gun_firing_mode), 32'd0);
    check("mode_fire", 32'(gun_fire_command), 32'd1);
    req = 4'b0000;
    step();
    check("drop_gnt", 32'(gnt), 32'd0);
    check("drop_fire", 32'(gun_fire_command), 32'd0);
    check("drop_cause", 32'(release_cause), 32'b00);
    step();
    check("drop_pulse_once", 32'(release_pulse), 32'd0);
    repeat (GUARD - 1) step();

    // Downfall together with a request drop: downfall wins, single pulse, sticky
    req = 4'b0001;
    gnt_q.push_back(4'b0001);
    rel_q.push_back({2'b11, 8'd0});
    step(); step();
    check("down_pre_fire", 32'(gun_fire_command), 32'd1);
    gun_state = 3'b101; req = 4'b0000;
    step();
    check("down_gnt", 32'(gnt), 32'd0);
    check("down_fire", 32'(gun_fire_command), 32'd0);
    check("down_halted", 32'(halted), 32'd1);
    check("down_cause", 32'(release_cause), 32'b11);
    step();
    check("down_pulse_once", 32'(release_pulse), 32'd0);
    gun_state = 3'b000; req = 4'b1111;
    repeat (5) step();
    check("down_ignore_req", 32'(gnt), 32'd0);
    check("down_sticky", 32'(halted), 32'd1);

    // Reboot clears halt asynchronously; arbitration restarts from pointer 0
    reboot_n = 1'b0;
    #1;
    check("reboot_halted", 32'(halted), 32'd0);
    req = 4'b0000;
    step(); step();
    reboot_n = 1'b1;
    req = 4'b0001;
    gnt_q.push_back(4'b0001);
    step();
    check("reboot_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    rel_q.push_back({2'b00, 8'd0});
    step();
    repeat (GUARD) step();

    // Async reset mid-tenure, then pointer must be back at 0
    req = 4'b0100;
    gnt_q.push_back(4'b0100);
    step(); step();
    check("async_pre_fire", 32'(gun_fire_command), 32'd1);
    #2;
    reboot_n = 1'b0;
    #1;
    check("async_gnt", 32'(gnt), 32'd0);
    check("async_fire", 32'(gun_fire_command), 32'd0);
    @(posedge clk);
    #1;
    reboot_n = 1'b1;
    req = 4'b0101;
    gnt_q.push_back(4'b0001);
    step();
    check("async_ptr_gnt", 32'(gnt), 32'b0001);
    req = 4'b0000;
    rel_q.push_back({2'b00, 8'd0});
    step();
    repeat (GUARD) step();

    @(negedge clk);
    #1;
    check("sb_gnt_left", 32'(gnt_q.size()), 32'd0);
    check("sb_rel_left", 32'(rel_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
